calc_key_entry: RTL and testbench
=================================

Name: calc_key_entry

Overview:
- Operand/opcode entry sequencer sitting directly upstream of the calculator ALU.
- Converts a stream of single-cycle key events (digits, sign, clear, equals, operation keys) into a signed operand pair plus a 5-bit ALU opcode.
- Presents them to the ALU input register through a valid/ready handshake.
- Also drives the value currently being typed for the display path.

Parameters:
- OPCODE_LENGTH, 5, opcode width (matches ALU).
- NUM_LENGTH, 9, signed operand width (matches ALU).
- MAG_MAX, 255, largest operand magnitude accepted during entry.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  one-cycle key event strobe.
- key_is_op  input  1  qualifies key_data: 1 = ALU opcode, 0 = command.
- key_data  input  5  opcode when key_is_op=1; else 0-9 digit, 10 equals, 11 clear, 12 negate, 13-31 reserved.
- op_ready  input  1  downstream accepts issued operation.
- op_valid  output  1  operation pending.
- opcode  output  OPCODE_LENGTH  issued ALU opcode.
- num_a  output  NUM_LENGTH  signed operand A.
- num_b  output  NUM_LENGTH  signed operand B (0 for unary ops).
- disp_value  output  NUM_LENGTH  signed value of operand currently being entered.
- entry_err  output  1  sticky overflow flag.
- key_drop  output  1  one-cycle pulse when a key is ignored.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: op_valid=0, opcode=0, num_a=0, num_b=0, disp_value=0, entry_err=0, key_drop=0.
  - State: ENTER_A; both magnitudes 0, both sign flags 0, pending opcode 0, b_empty=1.
  - Reset mid-ISSUE drops the pending operation.
- States:
  - ENTER_A: digits, negate and clear edit A.
  - ENTER_B: editing B with a binary opcode pending.
  - ISSUE: handshake in progress.
- Operand encoding: 8-bit magnitude + sign flag. Value = sign ? -mag : mag, sign-extended to NUM_LENGTH. Magnitude 0 with sign 1 yields 0.
- Digit d:
  - tmp = mag*10 + d, computed in 12 bits.
  - If tmp <= MAG_MAX: mag <= tmp.
  - Else: mag unchanged, entry_err <= 1, key_drop pulses.
  - In ENTER_B, a digit also clears b_empty.
- Negate: toggles the sign flag of the current operand.
- Clear: in ENTER_A/ENTER_B, returns to ENTER_A, zeroes both operands and signs, clears entry_err, sets b_empty=1.
- Opcode classes:
  - Binary: 00000, 00001, 00010, 00011, 01011.
  - Unary: every other value, including memory ops 10001, 10010, 10100, 11000.
- Op key in ENTER_A:
  - Binary: latch opcode, go to ENTER_B.
  - Unary: latch opcode, num_b=0, go to ISSUE.
- Op key in ENTER_B:
  - If b_empty=1, behaves exactly as in ENTER_A (replaces pending op).
  - Otherwise ignored, key_drop pulses.
- Equals:
  - In ENTER_B, go to ISSUE with current A, B, opcode.
  - In ENTER_A, ignored, key_drop pulses.
- Reserved command codes: ignored, key_drop pulses.
- ISSUE:
  - op_valid=1 from the cycle after the issuing key.
  - opcode/num_a/num_b registered and held stable while op_valid=1.
  - Transfer completes on the edge where op_valid && op_ready.
  - Next cycle: op_valid=0, state ENTER_A, both operands/signs zeroed, b_empty=1.
  - entry_err is not cleared by issue.
  - op_ready is ignored outside ISSUE.
- Keys in ISSUE (any, including clear): ignored, key_drop pulses. A key arriving in the same cycle as the handshake is also dropped.
- disp_value: registered value of A in ENTER_A, of B in ENTER_B, and the issued num_a in ISSUE. Updates the cycle after each accepted key.
- Latency:
  - Unary op key to op_valid: 1 cycle.
  - Equals to op_valid: 1 cycle.
  - Combinational paths from inputs to outputs: none.

Test Plan:
- Reset mid-ISSUE: "9", op 00010, "9", equals, hold op_ready=0, assert rst_n=0 -> all outputs 0 asynchronously; after release, state ENTER_A and disp_value=0.
- Binary add: keys "1","2", op 00000, "3","4", equals, op_ready=1 -> op_valid one cycle with opcode=00000, num_a=12, num_b=34; disp_value=0 afterward.
- Unary with negate: "2","5", negate, op 00100 -> next cycle op_valid=1, opcode=00100, num_a=-25 (9'h1E7), num_b=0.
- Overflow: "2","5","5","9" -> "9" dropped (key_drop pulse), mag=255, entry_err=1. Clear -> entry_err=0, disp_value=0.
- Backpressure: issue 7-3 with op_ready=0 for 5 cycles while pressing "5" and clear -> outputs stable; both keys dropped (2 key_drop pulses). op_ready=1 -> single transfer, then ENTER_A.
- Op replacement and misuse:
  - equals in ENTER_A -> key_drop.
  - "8", op 00000, op 00001, "2", equals -> opcode=00001, num_a=8, num_b=2.
  - Op key after a B digit -> dropped.

Source files
------------

// File: rtl/calc_key_entry.sv
// Key-entry sequencer ahead of the calculator ALU: turns digit/sign/clear/equals/op
// key strobes into a signed operand pair plus opcode, offered over valid/ready.
module calc_key_entry #(
  parameter int OPCODE_LENGTH = 5,
  parameter int NUM_LENGTH    = 9,
  parameter int MAG_MAX       = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_valid,
  input  logic                     key_is_op,
  input  logic [4:0]               key_data,
  input  logic                     op_ready,
  output logic                     op_valid,
  output logic [OPCODE_LENGTH-1:0] opcode,
  output logic [NUM_LENGTH-1:0]    num_a,
  output logic [NUM_LENGTH-1:0]    num_b,
  output logic [NUM_LENGTH-1:0]    disp_value,
  output logic                     entry_err,
  output logic                     key_drop
);

  // Handshake: op_valid rises the cycle after the issuing key, opcode/num_a/num_b
  // hold while op_valid=1, and the transfer happens on the edge with op_valid && op_ready.
  typedef enum logic [1:0] {ST_ENTER_A, ST_ENTER_B, ST_ISSUE} state_t;

  state_t r_state, w_state_n;
  logic [7:0] r_mag_a, r_mag_b, w_mag_a_n, w_mag_b_n;
  logic r_sign_a, r_sign_b, w_sign_a_n, w_sign_b_n;
  logic r_b_empty, w_b_empty_n;
  logic [OPCODE_LENGTH-1:0] r_pend_op, w_pend_op_n;
  logic r_op_valid, w_op_valid_n;
  logic [OPCODE_LENGTH-1:0] r_opcode, w_opcode_n;
  logic [NUM_LENGTH-1:0] r_num_a, r_num_b, r_disp, w_num_a_n, w_num_b_n, w_disp_n;
  logic r_err, w_err_n, r_drop, w_drop_n;
  logic [7:0] w_cur_mag;
  logic [11:0] w_tmp;
  logic w_digit_ok;
  logic [OPCODE_LENGTH-1:0] w_key_op;

  function automatic logic [NUM_LENGTH-1:0] to_val(input logic [7:0] mag, input logic sign);
    logic [NUM_LENGTH-1:0] v;
    v = NUM_LENGTH'(mag);
    if (sign) v = -v;
    return v;
  endfunction

  function automatic logic is_binary(input logic [OPCODE_LENGTH-1:0] op);
    return (op == OPCODE_LENGTH'(0)) || (op == OPCODE_LENGTH'(1)) ||
           (op == OPCODE_LENGTH'(2)) || (op == OPCODE_LENGTH'(3)) ||
           (op == OPCODE_LENGTH'(11));
  endfunction

  assign w_key_op   = OPCODE_LENGTH'(key_data);
  assign w_cur_mag  = (r_state == ST_ENTER_B) ? r_mag_b : r_mag_a;
  assign w_tmp      = 12'(w_cur_mag) * 12'd10 + 12'(key_data);
  assign w_digit_ok = (w_tmp <= 12'(MAG_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ENTER_A;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n    = r_state;
    w_mag_a_n    = r_mag_a;
    w_mag_b_n    = r_mag_b;
    w_sign_a_n   = r_sign_a;
    w_sign_b_n   = r_sign_b;
    w_b_empty_n  = r_b_empty;
    w_pend_op_n  = r_pend_op;
    w_op_valid_n = r_op_valid;
    w_opcode_n   = r_opcode;
    w_num_a_n    = r_num_a;
    w_num_b_n    = r_num_b;
    w_err_n      = r_err;
    w_drop_n     = 1'b0;
    if (r_state == ST_ISSUE) begin
      if (key_valid) w_drop_n = 1'b1;
      if (op_ready) begin
        w_state_n    = ST_ENTER_A;
        w_op_valid_n = 1'b0;
        w_mag_a_n    = '0;
        w_mag_b_n    = '0;
        w_sign_a_n   = 1'b0;
        w_sign_b_n   = 1'b0;
        w_b_empty_n  = 1'b1;
      end
    end else if (key_valid) begin
      if (key_is_op) begin
        // An op key in ENTER_B only replaces the pending op while B is still untouched.
        if (r_state == ST_ENTER_A || r_b_empty) begin
          w_pend_op_n = w_key_op;
          if (is_binary(w_key_op)) begin
            w_state_n = ST_ENTER_B;
          end else begin
            w_state_n    = ST_ISSUE;
            w_op_valid_n = 1'b1;
            w_opcode_n   = w_key_op;
            w_num_a_n    = to_val(r_mag_a, r_sign_a);
            w_num_b_n    = '0;
          end
        end else begin
          w_drop_n = 1'b1;
        end
      end else if (key_data <= 5'd9) begin
        if (w_digit_ok) begin
          if (r_state == ST_ENTER_B) begin
            w_mag_b_n   = w_tmp[7:0];
            w_b_empty_n = 1'b0;
          end else begin
            w_mag_a_n = w_tmp[7:0];
          end
        end else begin
          w_err_n  = 1'b1;
          w_drop_n = 1'b1;
        end
      end else if (key_data == 5'd10) begin
        if (r_state == ST_ENTER_B) begin
          w_state_n    = ST_ISSUE;
          w_op_valid_n = 1'b1;
          w_opcode_n   = r_pend_op;
          w_num_a_n    = to_val(r_mag_a, r_sign_a);
          w_num_b_n    = to_val(r_mag_b, r_sign_b);
        end else begin
          w_drop_n = 1'b1;
        end
      end else if (key_data == 5'd11) begin
        w_state_n   = ST_ENTER_A;
        w_mag_a_n   = '0;
        w_mag_b_n   = '0;
        w_sign_a_n  = 1'b0;
        w_sign_b_n  = 1'b0;
        w_b_empty_n = 1'b1;
        w_err_n     = 1'b0;
      end else if (key_data == 5'd12) begin
        if (r_state == ST_ENTER_B) w_sign_b_n = ~r_sign_b;
        else                       w_sign_a_n = ~r_sign_a;
      end else begin
        w_drop_n = 1'b1;
      end
    end
    case (w_state_n)
      ST_ENTER_B: w_disp_n = to_val(w_mag_b_n, w_sign_b_n);
      ST_ISSUE:   w_disp_n = w_num_a_n;
      default:    w_disp_n = to_val(w_mag_a_n, w_sign_a_n);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_b_empty  <= 1'b1;
      r_pend_op  <= '0;
      r_op_valid <= 1'b0;
      r_opcode   <= '0;
      r_num_a    <= '0;
      r_num_b    <= '0;
      r_disp     <= '0;
      r_err      <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_mag_a    <= w_mag_a_n;
      r_mag_b    <= w_mag_b_n;
      r_sign_a   <= w_sign_a_n;
      r_sign_b   <= w_sign_b_n;
      r_b_empty  <= w_b_empty_n;
      r_pend_op  <= w_pend_op_n;
      r_op_valid <= w_op_valid_n;
      r_opcode   <= w_opcode_n;
      r_num_a    <= w_num_a_n;
      r_num_b    <= w_num_b_n;
      r_disp     <= w_disp_n;
      r_err      <= w_err_n;
      r_drop     <= w_drop_n;
    end
  end

  assign op_valid   = r_op_valid;
  assign opcode     = r_opcode;
  assign num_a      = r_num_a;
  assign num_b      = r_num_b;
  assign disp_value = r_disp;
  assign entry_err  = r_err;
  assign key_drop   = r_drop;

endmodule

// File: tb/tb_calc_key_entry.sv
// Bench for calc_key_entry: directed key sequences plus random keys, every cycle
// compared against an integer-level calculator-entry model and an issue queue.
module tb_calc_key_entry;

  logic       clk, rst_n, key_valid, key_is_op, op_ready;
  logic [4:0] key_data;
  logic       op_valid, entry_err, key_drop;
  logic [4:0] opcode;
  logic [8:0] num_a, num_b, disp_value;

  int n_checks = 0;
  int n_errors = 0;

  // Model: which operand is being typed (0 = A, 1 = B, 2 = waiting on ALU).
  int m_mode, m_mag_a, m_mag_b, m_pend, m_opc, m_a, m_b, m_disp;
  bit m_neg_a, m_neg_b, m_b_empty, m_valid, m_err, m_drop;
  logic [22:0] exp_q[$];

  calc_key_entry dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_is_op(key_is_op),
    .key_data(key_data), .op_ready(op_ready), .op_valid(op_valid), .opcode(opcode),
    .num_a(num_a), .num_b(num_b), .disp_value(disp_value), .entry_err(entry_err),
    .key_drop(key_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int val(input int mag, input bit neg);
    return neg ? -mag : mag;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_mag_a = 0; m_mag_b = 0; m_neg_a = 0; m_neg_b = 0;
    m_b_empty = 1; m_pend = 0; m_valid = 0; m_opc = 0; m_a = 0; m_b = 0;
    m_err = 0; m_drop = 0; m_disp = 0;
    exp_q.delete();
  endtask

  task automatic model_issue(input int op, input int a, input int b);
    m_mode = 2; m_valid = 1; m_opc = op; m_a = a; m_b = b;
    exp_q.push_back({5'(op), 9'(a & 511), 9'(b & 511)});
  endtask

  task automatic model_step(input bit kv, input bit kop, input int kd, input bit rdy);
    int cur;
    m_drop = 0;
    if (m_mode == 2) begin
      if (kv) m_drop = 1;
      if (rdy) begin
        m_mode = 0; m_mag_a = 0; m_mag_b = 0; m_neg_a = 0; m_neg_b = 0;
        m_b_empty = 1; m_valid = 0;
      end
    end else if (kv) begin
      if (kop) begin
        if (m_mode == 0 || m_b_empty) begin
          m_pend = kd;
          if (kd inside {0, 1, 2, 3, 11}) m_mode = 1;
          else model_issue(kd, val(m_mag_a, m_neg_a), 0);
        end else m_drop = 1;
      end else if (kd <= 9) begin
        cur = (m_mode == 1) ? m_mag_b : m_mag_a;
        if (cur * 10 + kd <= 255) begin
          if (m_mode == 1) begin m_mag_b = cur * 10 + kd; m_b_empty = 0; end
          else m_mag_a = cur * 10 + kd;
        end else begin
          m_err = 1; m_drop = 1;
        end
      end else if (kd == 10) begin
        if (m_mode == 1) model_issue(m_pend, val(m_mag_a, m_neg_a), val(m_mag_b, m_neg_b));
        else m_drop = 1;
      end else if (kd == 11) begin
        m_mode = 0; m_mag_a = 0; m_mag_b = 0; m_neg_a = 0; m_neg_b = 0;
        m_b_empty = 1; m_err = 0;
      end else if (kd == 12) begin
        if (m_mode == 1) m_neg_b = !m_neg_b;
        else m_neg_a = !m_neg_a;
      end else m_drop = 1;
    end
    m_disp = (m_mode == 0) ? val(m_mag_a, m_neg_a) :
             (m_mode == 1) ? val(m_mag_b, m_neg_b) : m_a;
  endtask

  task automatic compare_all();
    check_val("op_valid", int'(op_valid), int'(m_valid));
    check_val("opcode", int'(opcode), m_opc & 31);
    check_val("num_a", int'(num_a), m_a & 511);
    check_val("num_b", int'(num_b), m_b & 511);
    check_val("disp_value", int'(disp_value), m_disp & 511);
    check_val("entry_err", int'(entry_err), int'(m_err));
    check_val("key_drop", int'(key_drop), int'(m_drop));
  endtask

  // One clock: drive at negedge, score any handshake, model the edge, compare after it.
  task automatic step(input bit kv, input bit kop, input int kd, input bit rdy);
    logic [22:0] e;
    @(negedge clk);
    key_valid = kv; key_is_op = kop; key_data = 5'(kd); op_ready = rdy;
    if (op_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check_val("xfer_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("xfer_op", int'({opcode, num_a, num_b}), int'(e));
      end
    end
    @(posedge clk);
    model_step(kv, kop, kd, rdy);
    #1;
    compare_all();
    key_valid = 1'b0;
  endtask

  task automatic dig(input int d);   step(1, 0, d, 0);  endtask
  task automatic cmd(input int c);   step(1, 0, c, 0);  endtask
  task automatic opk(input int o);   step(1, 1, o, 0);  endtask
  task automatic idle(input bit rdy); step(0, 0, 0, rdy); endtask

  initial begin
    int r, kd;
    bit kv, kop, rdy;
    rst_n = 1'b0; key_valid = 1'b0; key_is_op = 1'b0; key_data = '0; op_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk) rst_n = 1'b1;

    // Binary add 12 + 34
    dig(1); dig(2); opk(0); dig(3); dig(4); cmd(10);
    check_val("add_num_a", int'(num_a), 12);
    check_val("add_num_b", int'(num_b), 34);
    idle(1); idle(0);
    check_val("add_disp_after", int'(disp_value), 0);

    // Unary with negate: -25
    dig(2); dig(5); cmd(12); opk(5'b00100);
    check_val("unary_num_a", int'(num_a), 'h1E7);
    check_val("unary_valid", int'(op_valid), 1);
    idle(1);

    // Overflow then clear
    dig(2); dig(5); dig(5); dig(9);
    check_val("ovf_drop", int'(key_drop), 1);
    check_val("ovf_disp", int'(disp_value), 255);
    cmd(11);
    check_val("clr_err", int'(entry_err), 0);

    // Backpressure: 7 - 3, keys pressed while stalled
    dig(7); opk(1); dig(3); cmd(10);
    idle(0); dig(5); idle(0); cmd(11); idle(0);
    check_val("bp_num_a", int'(num_a), 7);
    idle(1); idle(0);

    // Misuse and op replacement
    cmd(10);
    check_val("eq_in_a_drop", int'(key_drop), 1);
    dig(8); opk(0); opk(1); dig(2); opk(2);
    check_val("op_after_b_drop", int'(key_drop), 1);
    cmd(10);
    check_val("repl_opcode", int'(opcode), 1);
    idle(1);

    // Reserved code and reset while issuing
    cmd(20);
    dig(9); opk(2); dig(9); cmd(10); idle(0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk) rst_n = 1'b1;
    idle(1);
    dig(5);

    // Random keys with random backpressure
    for (int i = 0; i < 2500; i++) begin
      kv = ($urandom_range(0, 9) < 6);
      kop = ($urandom_range(0, 9) < 3);
      rdy = $urandom_range(0, 1);
      if (kop) begin
        r = $urandom_range(0, 1);
        kd = r ? $urandom_range(0, 31) : $urandom_range(0, 4);
        if (!r && kd == 4) kd = 11;
      end else begin
        r = $urandom_range(0, 29);
        if (r < 20)      kd = $urandom_range(0, 9);
        else if (r < 24) kd = 10;
        else if (r < 25) kd = 11;
        else if (r < 28) kd = 12;
        else             kd = $urandom_range(13, 31);
      end
      step(kv, kop, kd, rdy);
    end
    repeat (3) idle(1);
    check_val("q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
